// File: rtl/alu_issue_sched_if.sv
// alu_issue_sched_if: issue-port, ALU-offer and flush/kill signals of the ALU issue scheduler.
// master drives requests, ALU status and flushes; slave is the scheduler.
interface alu_issue_sched_if #(
   parameter int NUM_REQ       = 4,
   parameter int ROB_ID_WIDTH  = 8,
   parameter int PAYLOAD_WIDTH = 128
);
   logic [NUM_REQ-1:0]               i_req_vld;
   logic [NUM_REQ*ROB_ID_WIDTH-1:0]  i_req_rob_id;
   logic [NUM_REQ*PAYLOAD_WIDTH-1:0] i_req_payload;
   logic [NUM_REQ-1:0]               o_req_gnt;
   logic                             o_alu_vld;
   logic                             i_alu_rdy;
   logic [ROB_ID_WIDTH-1:0]          o_alu_rob_id;
   logic [PAYLOAD_WIDTH-1:0]         o_alu_payload;
   logic                             i_alu_done;
   logic                             i_trap_flush;
   logic                             i_kill_vld;
   logic [ROB_ID_WIDTH-1:0]          i_kill_rob_id;
   logic                             o_sched_busy;
   modport master (
      output i_req_vld, i_req_rob_id, i_req_payload, i_alu_rdy, i_alu_done,
             i_trap_flush, i_kill_vld, i_kill_rob_id,
      input  o_req_gnt, o_alu_vld, o_alu_rob_id, o_alu_payload, o_sched_busy
   );
   modport slave (
      input  i_req_vld, i_req_rob_id, i_req_payload, i_alu_rdy, i_alu_done,
             i_trap_flush, i_kill_vld, i_kill_rob_id,
      output o_req_gnt, o_alu_vld, o_alu_rob_id, o_alu_payload, o_sched_busy
   );
endinterface

// File: rtl/alu_issue_sched.sv
// alu_issue_sched: oldest-first issue of reservation-station ops into a single ALU, with kill/trap flushing.
// ALU_ISSUE_SCHED_STARVE_EN adds per-port wait counters; a port waiting 15 cycles beats age ordering.
module alu_issue_sched #(
   parameter int NUM_REQ       = 4,
   parameter int ROB_ID_WIDTH  = 8,
   parameter int PAYLOAD_WIDTH = 128
) (
   input logic clk,
   input logic rst,
   alu_issue_sched_if.slave bus
);
   localparam int W = ROB_ID_WIDTH;
   localparam int P = PAYLOAD_WIDTH;
   typedef enum logic [1:0] {EMPTY, OFFER, EXEC} state_t;
   state_t state, state_d;
   logic [W-1:0] rob_q, sel_id;
   logic [P-1:0] pay_q, sel_pay;
   logic [NUM_REQ-1:0] elig, pick, gnt;
   logic held_kill;
   // Ids wrap: the MSB flips on each pass through the ROB, so a differing MSB inverts the index order.
   function automatic logic older(input logic [W-1:0] a, input logic [W-1:0] b);
      return (a[W-1] != b[W-1]) ? (a[W-2:0] >= b[W-2:0]) : (a[W-2:0] < b[W-2:0]);
   endfunction
`ifdef ALU_ISSUE_SCHED_STARVE_EN
   logic [3:0] wait_cnt [NUM_REQ];
   always_ff @(posedge clk)
      for (int k = 0; k < NUM_REQ; k++)
         if (rst || !bus.i_req_vld[k] || gnt[k])
            wait_cnt[k] <= 4'd0;
         else if (wait_cnt[k] != 4'd15)
            wait_cnt[k] <= wait_cnt[k] + 4'd1;
`endif
   always_comb begin
      elig = '0;
      pick = '0;
      sel_id = '0;
      sel_pay = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         elig[k] = bus.i_req_vld[k] && !(bus.i_kill_vld && older(bus.i_kill_rob_id, bus.i_req_rob_id[k*W +: W]));
         // Strictly-older replacement keeps the lowest index on equal ids.
         if (elig[k] && (pick == '0 || older(bus.i_req_rob_id[k*W +: W], sel_id))) begin
            pick = '0;
            pick[k] = 1'b1;
            sel_id = bus.i_req_rob_id[k*W +: W];
            sel_pay = bus.i_req_payload[k*P +: P];
         end
      end
`ifdef ALU_ISSUE_SCHED_STARVE_EN
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (elig[k] && wait_cnt[k] == 4'd15) begin
            pick = '0;
            pick[k] = 1'b1;
            sel_id = bus.i_req_rob_id[k*W +: W];
            sel_pay = bus.i_req_payload[k*P +: P];
         end
`endif
   end
   assign gnt = (state == EMPTY && !bus.i_trap_flush && !rst) ? pick : '0;
   assign held_kill = bus.i_kill_vld && older(bus.i_kill_rob_id, rob_q);
   always_comb begin
      state_d = state;
      case (state)
         EMPTY:   state_d = (gnt != '0) ? OFFER : EMPTY;
         OFFER:   state_d = held_kill ? EMPTY : bus.i_alu_rdy ? EXEC : OFFER;
         EXEC:    state_d = (held_kill || bus.i_alu_done) ? EMPTY : EXEC;
         default: state_d = EMPTY;
      endcase
      if (bus.i_trap_flush)
         state_d = EMPTY;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= EMPTY;
         rob_q <= '0;
         pay_q <= '0;
      end else begin
         state <= state_d;
         if (gnt != '0) begin
            rob_q <= sel_id;
            pay_q <= sel_pay;
         end
      end
   assign bus.o_req_gnt     = gnt;
   assign bus.o_alu_vld     = state == OFFER;
   assign bus.o_alu_rob_id  = rob_q;
   assign bus.o_alu_payload = pay_q;
   assign bus.o_sched_busy  = state != EMPTY;
endmodule
